i2c_slave_target: RTL
=====================

// Module: i2c_slave_target
// PURPOSE
//  I2C target (responder) for the far end of the bus driven by the team's i2c_core master.
//  Decodes START/STOP, matches a 7-bit address, ACKs, and moves bytes between SDA and a register-file port.
//  Write transfer: first byte after address sets the register pointer; later bytes write registers.
//  Read transfer: bytes are read from the pointer. The pointer auto-increments after every byte.
// PARAMETERS
//  SLV_ADDR  7'h50  7-bit target address compared against the first byte after START
//  AW        8      register pointer width; wraps 2^AW-1 -> 0
// PORTS
//  pclk        in   1   system clock; must be >= 8x SCL frequency
//  prst_n      in   1   asynchronous reset, active low
//  scl_in      in   1   SCL pad input (asynchronous)
//  sda_in      in   1   SDA pad input (asynchronous)
//  sda_oe      out  1   1 = pull SDA low (open drain); pad drives Z when 0
//  reg_addr    out  AW  register pointer
//  reg_wdata   out  8   write data, valid with reg_wr_en
//  reg_wr_en   out  1   one-pclk write strobe
//  reg_rd_en   out  1   one-pclk read strobe; reg_rdata is sampled on the next pclk
//  reg_rdata   in   8   read data
//  busy        out  1   1 from address match until STOP, or until START addressed to another target
//  addr_hit    out  1   one-pclk pulse on address match
// BEHAVIOUR
//  Reset values: all outputs 0; FSM=IDLE; pointer 0. prst_n low mid-transfer releases SDA at once.
//  Input path: 2-flop sync on scl_in/sda_in, then edge detect on the synced values.
//   Edge and START/STOP detection latency is 2-3 pclk.
//  START: SDA falls while SCL high. STOP: SDA rises while SCL high.
//   Both are recognised in any state and take priority over bit processing.
//   START (including repeated START) -> ADDR, bit counter cleared. STOP -> IDLE, sda_oe=0, busy=0.
//  Bit timing: sample SDA on SCL rising edge. Change sda_oe only on SCL falling edge.
//  FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_ACK, IGNORE.
//   ADDR: shift 8 bits, MSB first. On the 8th falling edge:
//    - match -> ADDR_ACK, sda_oe=1, addr_hit pulse, busy=1;
//    - no match -> IGNORE.
//   ADDR_ACK: on the next falling edge, release SDA, then:
//    - R/W=0 -> PTR;
//    - R/W=1 -> RDATA.
//   PTR: 8 bits -> pointer; -> PTR_ACK (ACK driven) -> WDATA.
//   WDATA: 8 bits -> reg_wdata and reg_wr_en at the 8th falling edge; -> WDATA_ACK (ACK) -> WDATA.
//    Pointer increments one pclk after reg_wr_en.
//   RDATA: reg_rd_en pulses at entry (ADDR_ACK start, or RD_ACK exit).
//    reg_rdata loads the shift register the next pclk. Drive MSB at the first falling edge.
//    sda_oe = ~bit. After 8 bits release SDA -> RD_ACK; pointer increments.
//   RD_ACK: sample master bit on rising edge.
//    - 0 (ACK) -> RDATA with prefetch from the new pointer;
//    - 1 (NACK) -> IGNORE (SDA released until STOP/START).
//   IGNORE: sda_oe=0; only START/STOP exit.
//  Boundaries:
//   - pointer wraps 0xFF -> 0x00 with no error;
//   - STOP directly after PTR byte: no write;
//   - write with zero data bytes: pointer updated only;
//   - repeated START after PTR then read: reads from the new pointer;
//   - START/STOP on the same pclk as an SCL edge: START/STOP wins;
//   - general call (0x00) not acknowledged.
// CONFIGURATION
//  I2C_SLV_GLITCH_FILTER_EN defined:
//   adds a 3-sample majority filter after the synchronisers on SCL and SDA; rejects pulses < 2 pclk;
//   detection latency +2 pclk.
//  Undefined: synchronisers only; pulses >= 1 pclk may be seen as edges.
// STRUCTURE
//  Shared package/define file (n2v_define.v): the FSM state encodings (4-bit) and I2C_ACK=1'b0, I2C_NACK=1'b1.
//  One sub-module: i2c_slv_line_sync. It holds the sync + optional filter + rise/fall/START/STOP detect,
//   instantiated once for the SCL/SDA pair. The FSM, shifter and pointer stay in i2c_slave_target.
// TESTING
//  1 Drive master write: 0xA0, ptr 0x10, 0x5A, 0xC3, STOP at 100 kHz, pclk 50 MHz
//    -> ACK on all four bytes; reg_wr_en @0x10=0x5A, @0x11=0xC3; busy 0 after STOP.
//  2 Drive write 0xA0 ptr 0x20, repeated START, 0xA1, read 3 bytes (ACK, ACK, NACK) with reg model mem[i]=i^0xFF
//    -> SDA bytes 0xDF, 0xDE, 0xDD; three reg_rd_en pulses.
//  3 Drive address 0xA2 followed by 2 bytes
//    -> sda_oe never 1; no addr_hit, no reg strobes.
//  4 Drive write ptr 0xFF, data 0x11, 0x22
//    -> writes @0xFF then @0x00 (wrap).
//  5 Assert prst_n low during a read bit where sda_oe=1
//    -> sda_oe=0 immediately; next START+0xA0 ACKed normally.
//  6 With I2C_SLV_GLITCH_FILTER_EN, inject 1-pclk SCL glitches mid-byte
//    -> byte received correctly; without the macro the bench marks the glitch as a bit error.

Source files
------------

// File: rtl/i2c_slave_target_pkg.sv
// i2c_slave_target_pkg: FSM state encodings and ACK bit levels shared by the I2C target
package i2c_slave_target_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        PTR       = 4'd3,
        PTR_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        RD_ACK    = 4'd8,
        IGNORE    = 4'd9
    } state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_slv_line_sync.sv
// i2c_slv_line_sync: synchronises SCL/SDA, optionally majority-filters them, detects SCL edges and START/STOP
// Ports: clk, rst_n (async, active low); scl_in/sda_in asynchronous pads;
//   sda clean SDA level; scl_rise/scl_fall/start/stop one-clk pulses.
// Build option: I2C_SLV_GLITCH_FILTER_EN adds a 3-sample majority filter (rejects pulses < 2 clk, +2 clk latency).
module i2c_slv_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [1:0] scl_s, sda_s;
    logic       scl_f, sda_f, scl_q, sda_q;

    // Reset to the idle bus level so leaving reset never fakes an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_s <= 2'b11;
            sda_s <= 2'b11;
        end else begin
            scl_s <= {scl_s[0], scl_in};
            sda_s <= {sda_s[0], sda_in};
        end
    end

`ifdef I2C_SLV_GLITCH_FILTER_EN
    logic [1:0] scl_h, sda_h;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_h <= 2'b11;
            sda_h <= 2'b11;
            scl_f <= 1'b1;
            sda_f <= 1'b1;
        end else begin
            scl_h <= {scl_h[0], scl_s[1]};
            sda_h <= {sda_h[0], sda_s[1]};
            scl_f <= (scl_s[1] & scl_h[0]) | (scl_s[1] & scl_h[1]) | (scl_h[0] & scl_h[1]);
            sda_f <= (sda_s[1] & sda_h[0]) | (sda_s[1] & sda_h[1]) | (sda_h[0] & sda_h[1]);
        end
    end
`else
    assign scl_f = scl_s[1];
    assign sda_f = sda_s[1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_f;
            sda_q <= sda_f;
        end
    end

    assign sda      = sda_f;
    assign scl_rise = scl_f & ~scl_q;
    assign scl_fall = ~scl_f & scl_q;
    assign start    = scl_f & scl_q & sda_q & ~sda_f;
    assign stop     = scl_f & scl_q & ~sda_q & sda_f;

endmodule

// File: rtl/i2c_slave_target.sv
// i2c_slave_target: I2C target with 7-bit address match, auto-incrementing register pointer and register-file port
// Ports: pclk, prst_n (async, active low); scl_in/sda_in asynchronous pads; sda_oe open-drain pull-down;
//   reg_addr/reg_wdata/reg_wr_en/reg_rd_en/reg_rdata register-file port (rdata sampled the pclk after reg_rd_en);
//   busy from address match to STOP; addr_hit one-pclk pulse on address match.
// Build option: I2C_SLV_GLITCH_FILTER_EN enables the SCL/SDA majority filter inside i2c_slv_line_sync.
module i2c_slave_target
    import i2c_slave_target_pkg::*;
#(
    parameter logic [6:0] SLV_ADDR = 7'h50,
    parameter int         AW       = 8
) (
    input  logic          pclk,
    input  logic          prst_n,
    input  logic          scl_in,
    input  logic          sda_in,
    output logic          sda_oe,
    output logic [AW-1:0] reg_addr,
    output logic [7:0]    reg_wdata,
    output logic          reg_wr_en,
    output logic          reg_rd_en,
    input  logic [7:0]    reg_rdata,
    output logic          busy,
    output logic          addr_hit
);

    state_t     state, state_nxt;
    logic       sda, scl_rise, scl_fall, start, stop;
    logic [3:0] cnt;
    logic [7:0] rx, tx;
    logic       rw, last, match;
    logic       oe_nxt, busy_nxt, cnt_clr, hit, wr, rd, ptr_ld, ptr_inc;

    i2c_slv_line_sync u_sync (
        .clk     (pclk),
        .rst_n   (prst_n),
        .scl_in  (scl_in),
        .sda_in  (sda_in),
        .sda     (sda),
        .scl_rise(scl_rise),
        .scl_fall(scl_fall),
        .start   (start),
        .stop    (stop)
    );

    assign last  = cnt == 4'd8;
    assign match = rx[7:1] == SLV_ADDR && rx[7:1] != 7'd0;

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) state <= IDLE;
        else         state <= state_nxt;
    end

    // cnt counts SCL rising edges within the current byte; the falling edge after the 8th ends the byte
    always_comb begin
        state_nxt = state;
        oe_nxt    = sda_oe;
        busy_nxt  = busy;
        cnt_clr   = 1'b0;
        hit       = 1'b0;
        wr        = 1'b0;
        rd        = 1'b0;
        ptr_ld    = 1'b0;
        ptr_inc   = 1'b0;
        if (stop) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
        end else if (start) begin
            state_nxt = ADDR;
            cnt_clr   = 1'b1;
        end else if (scl_fall) begin
            case (state)
                ADDR: if (last) begin
                    cnt_clr   = 1'b1;
                    state_nxt = match ? ADDR_ACK : IGNORE;
                    oe_nxt    = match ? ~I2C_ACK : 1'b0;
                    busy_nxt  = match;
                    hit       = match;
                    rd        = match & rx[0];
                end
                ADDR_ACK: begin
                    cnt_clr   = 1'b1;
                    state_nxt = rw ? RDATA : PTR;
                    oe_nxt    = rw & ~tx[7];
                end
                PTR: if (last) begin
                    cnt_clr   = 1'b1;
                    state_nxt = PTR_ACK;
                    oe_nxt    = ~I2C_ACK;
                    ptr_ld    = 1'b1;
                end
                PTR_ACK, WDATA_ACK: begin
                    cnt_clr   = 1'b1;
                    state_nxt = WDATA;
                    oe_nxt    = 1'b0;
                end
                WDATA: if (last) begin
                    cnt_clr   = 1'b1;
                    state_nxt = WDATA_ACK;
                    oe_nxt    = ~I2C_ACK;
                    wr        = 1'b1;
                end
                // ~cnt[2:0] == 7-cnt: bit cnt of the byte is driven after the cnt-th rising edge
                RDATA: begin
                    oe_nxt = last ? 1'b0 : ~tx[~cnt[2:0]];
                    if (last) begin
                        cnt_clr   = 1'b1;
                        state_nxt = RD_ACK;
                        ptr_inc   = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (scl_rise && state == RD_ACK) begin
            cnt_clr   = 1'b1;
            state_nxt = sda == I2C_NACK ? IGNORE : RDATA;
            rd        = sda != I2C_NACK;
        end
        if (state_nxt inside {IDLE, ADDR, IGNORE}) oe_nxt = 1'b0;
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            addr_hit  <= 1'b0;
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            reg_wdata <= '0;
            reg_addr  <= '0;
            cnt       <= '0;
            rx        <= '0;
            tx        <= '0;
            rw        <= 1'b0;
        end else begin
            sda_oe    <= oe_nxt;
            busy      <= busy_nxt;
            addr_hit  <= hit;
            reg_wr_en <= wr;
            reg_rd_en <= rd;
            cnt       <= cnt_clr ? 4'd0 : cnt + {3'd0, scl_rise};
            if (scl_rise) rx <= {rx[6:0], sda};
            if (hit) rw <= rx[0];
            if (wr) reg_wdata <= rx;
            if (reg_rd_en) tx <= reg_rdata;
            // Write pointer steps the pclk after the strobe so reg_addr is stable while reg_wr_en is high
            reg_addr  <= ptr_ld ? AW'(rx) : (reg_wr_en | ptr_inc) ? reg_addr + 1'b1 : reg_addr;
        end
    end

endmodule
